// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce/synchroniser front end.
package debounce_pkg;

    // Two stable levels and two qualification states, one per direction.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        PEND_LOW    = 2'b11
    } deb_state_e;

    localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with synchronous reset to 0. Nothing sits between
// the two flops so the first stage has a full cycle to resolve.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    logic s1_q;
    logic s2_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
        end
    end

    assign out = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a bouncy pin and only lets a new level through after it has
// been seen for STABLE_CYCLES consecutive synchronised samples. Produces a
// clean level plus single-cycle rise/fall strobes.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    // Count value on which a qualification run completes.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s2;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             d_q;
    logic             rise_q;
    logic             fall_q;
    logic             pend_q;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .in  (raw_in),
        .out (s2)
    );

    // Qualification FSM; every output is registered alongside the state so
    // pending tracks the PEND_* states exactly and the strobes last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    if (s2) begin
                        state_q <= PEND_HIGH;
                        cnt_q   <= CNT_ONE;
                        pend_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                PEND_HIGH: begin
                    // A revert wins even on the final qualifying edge.
                    if (!s2) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        d_q     <= 1'b1;
                        rise_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s2) begin
                        state_q <= PEND_LOW;
                        cnt_q   <= CNT_ONE;
                        pend_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                PEND_LOW: begin
                    if (s2) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        d_q     <= 1'b0;
                        fall_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    d_q     <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d_out   = d_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with STABLE_CYCLES=4. Each vector sets
// the inputs ahead of one clock edge and queues the expected
// {d_out, rise, fall, pending} for that edge; the monitor pops and compares
// 5 time units after each posedge.
module tb_debounce_sync;

    logic clk;
    logic rst;
    logic raw_in;
    logic d_out;
    logic rise;
    logic fall;
    logic pending;

    typedef struct {
        int         e;
        logic [3:0] v;
    } exp_t;

    exp_t q[$];
    int   edge_n  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    debounce_sync #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .d_out   (d_out),
        .rise    (rise),
        .fall    (fall),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: compare every queued expectation that is due at this edge.
    always @(posedge clk) begin
        #5;
        while (q.size() > 0 && q[0].e <= edge_n) begin
            exp_t x;
            logic [3:0] act;
            x   = q.pop_front();
            act = {d_out, rise, fall, pending};
            n_tests++;
            if (x.e != edge_n || act !== x.v) begin
                n_fail++;
                $display("FAIL edge%0d: {d_out,rise,fall,pending} got %b at edge %0d, expected %b",
                         x.e, act, edge_n, x.v);
            end
        end
    end

    // Apply inputs for the next edge and queue what should follow it.
    task automatic vec(input logic r, input logic w, input logic [3:0] ev);
        exp_t x;
        @(negedge clk);
        rst    = r;
        raw_in = w;
        x.e    = edge_n + 1;
        x.v    = ev;
        q.push_back(x);
    endtask

    initial begin
        exp_t x0;
        rst    = 1'b1;
        raw_in = 1'b1;
        x0.e   = 1;
        x0.v   = 4'b0000;
        q.push_back(x0);
        // Reset held with raw_in=1
        vec(1, 1, 4'b0000);                       // e2
        // Idle low after release
        vec(0, 0, 4'b0000);                       // e3
        vec(0, 0, 4'b0000);
        vec(0, 0, 4'b0000);
        // Clean rise: raw_in=1 before e6, d_out at e11
        vec(0, 1, 4'b0000);                       // e6
        vec(0, 1, 4'b0000);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b1100);                       // e11
        vec(0, 1, 4'b1000);
        vec(0, 1, 4'b1000);
        // Clean fall: raw_in=0 before e14, d_out drops at e19
        vec(0, 0, 4'b1000);                       // e14
        vec(0, 0, 4'b1000);
        vec(0, 0, 4'b1001);
        vec(0, 0, 4'b1001);
        vec(0, 0, 4'b1001);
        vec(0, 0, 4'b0010);                       // e19
        vec(0, 0, 4'b0000);
        vec(0, 0, 4'b0000);
        // Two-cycle glitch: pending for exactly two edges, nothing else
        vec(0, 1, 4'b0000);                       // e22
        vec(0, 1, 4'b0000);
        vec(0, 0, 4'b0001);
        vec(0, 0, 4'b0001);
        vec(0, 0, 4'b0000);
        vec(0, 0, 4'b0000);
        vec(0, 0, 4'b0000);
        // Bouncy edge 1,0,1,0,1 then hold; last 0->1 before e33, rise at e38
        vec(0, 1, 4'b0000);                       // e29
        vec(0, 0, 4'b0000);
        vec(0, 1, 4'b0001);
        vec(0, 0, 4'b0000);
        vec(0, 1, 4'b0001);                       // e33
        vec(0, 1, 4'b0000);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b1100);                       // e38
        vec(0, 1, 4'b1000);
        // Fall back to low
        vec(0, 0, 4'b1000);                       // e40
        vec(0, 0, 4'b1000);
        vec(0, 0, 4'b1001);
        vec(0, 0, 4'b1001);
        vec(0, 0, 4'b1001);
        vec(0, 0, 4'b0010);                       // e45
        vec(0, 0, 4'b0000);
        // Reset in PEND_HIGH with cnt=2, then full requalification
        vec(0, 1, 4'b0000);                       // e47
        vec(0, 1, 4'b0000);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);                       // e50 cnt=2
        vec(1, 1, 4'b0000);                       // e51 reset
        vec(0, 1, 4'b0000);                       // e52 release
        vec(0, 1, 4'b0000);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b0001);
        vec(0, 1, 4'b1100);                       // e57
        vec(0, 1, 4'b1000);
        // Revert exactly on the final qualifying edge: bounce wins, no fall
        vec(0, 0, 4'b1000);                       // e59
        vec(0, 0, 4'b1000);
        vec(0, 0, 4'b1001);
        vec(0, 1, 4'b1001);
        vec(0, 1, 4'b1001);                       // e63 cnt=3
        vec(0, 1, 4'b1000);                       // e64 back to STABLE_HIGH
        vec(0, 1, 4'b1000);
        vec(0, 1, 4'b1000);
        repeat (2) @(negedge clk);
        n_tests++;
        if (d_out !== 1'b1) begin
            n_fail++;
            $display("FAIL final: d_out got %b, expected 1", d_out);
        end
        n_tests++;
        if (rise !== 1'b0) begin
            n_fail++;
            $display("FAIL final: rise got %b, expected 0", rise);
        end
        n_tests++;
        if (fall !== 1'b0) begin
            n_fail++;
            $display("FAIL final: fall got %b, expected 0", fall);
        end
        n_tests++;
        if (pending !== 1'b0) begin
            n_fail++;
            $display("FAIL final: pending got %b, expected 0", pending);
        end
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL edge%0d: expectation never checked, expected %b", x.e, x.v);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
